output_slice_scheduler: RTL and testbench
=========================================

OUTPUT_SLICE_SCHEDULER -- requirements
Module: output_slice_scheduler

Interface
REQ-001 SHALL have parameter MAX_SLICE_WIDTH, default 2560, the maximum slice width in pixels.
REQ-002 SHALL have parameter NUM_SLICES, default 4, the number of parallel slice output streams.
REQ-003 SHALL have parameter MAX_FRAME_HEIGHT, default 2160, the maximum number of picture lines.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port sof, input, 1 bit: one-cycle start-of-frame pulse that latches the configuration.
REQ-007 SHALL have port slice_width, input, $clog2(MAX_SLICE_WIDTH) bits: slice width in pixels.
REQ-008 SHALL have port slices_per_line, input, $clog2(NUM_SLICES)+1 bits: number of slices per picture line.
REQ-009 SHALL have port frame_height, input, $clog2(MAX_FRAME_HEIGHT)+1 bits: number of picture lines.
REQ-010 SHALL have port in_valid, input, NUM_SLICES bits: per-slice beat valid.
REQ-011 SHALL have port in_data_p, input, NUM_SLICES*4*3*14 bits: per slice, 4 pixels packed {p3c2,p3c1,p3c0,...,p0c0}; slice s occupies [s*168 +: 168].
REQ-012 SHALL have port in_ready, output, NUM_SLICES bits: per-slice beat accept.
REQ-013 SHALL have port out_valid, output, 1 bit; out_data_p, output, 168 bits; out_ready, input, 1 bit.
REQ-014 SHALL have ports out_sof, out_sol, out_eol and out_eof, each output, 1 bit: flags qualified by out_valid.

Function
REQ-015 SHALL run FSM IDLE -> ACTIVE on sof, ACTIVE -> DONE after the last beat of the last line, and DONE -> ACTIVE on sof.
REQ-016 SHALL latch slice_width, slices_per_line and frame_height on sof; the latched values are used until the next sof.
REQ-017 SHALL treat slices_per_line==0 as 1 and values above NUM_SLICES as NUM_SLICES.
REQ-018 SHALL compute beats per slice line as ceil(slice_width/4); a partial last beat is forwarded unmodified (pad pixels pass through).
REQ-019 SHALL, in ACTIVE, select slice sel starting at 0 and forward beats of slice sel only; in_ready[k]=0 for k!=sel.
REQ-020 SHALL hold one registered output stage and assert in_ready[sel] = ACTIVE & (~out_valid | out_ready).
REQ-021 SHALL make a beat accepted on cycle N appear on out_valid/out_data_p at cycle N+1, so latency is 1 cycle.
REQ-022 SHALL sustain 1 beat per cycle while in_valid[sel] and out_ready are both high.
REQ-023 SHALL hold out_data_p and flags stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, after the last beat of slice sel, advance sel; after slice slices_per_line-1, set sel=0 and increment the line counter.
REQ-025 SHALL assert out_sol on beat 0 of slice 0 and out_eol on the last beat of the last slice of each line.
REQ-026 SHALL assert out_sof on the first beat of the frame and out_eof on the last beat of line frame_height-1.
REQ-027 SHALL keep in_ready=0 in IDLE and DONE.
REQ-028 SHALL, on sof in any state including mid-line, clear out_valid, sel, the beat counter and the line counter next cycle and restart; sof wins over a simultaneous transfer, and that beat is dropped.
REQ-029 SHALL ignore in_valid on unselected slices, with no state change.

Reset
REQ-030 SHALL, on rst_n low, asynchronously set state=IDLE, out_valid=0, in_ready=0, all flags 0, sel=0 and counters 0.
REQ-031 SHALL leave out_data_p and the latched configuration unreset; they are don't-care until the first sof.

Configuration
REQ-032 SHALL, when macro OUTPUT_SLICE_SCHEDULER_STALL_CNT_EN is defined, add output stall_cnt (32 bits), which counts cycles with out_valid=1 & out_ready=0, saturates at 0xFFFFFFFF, clears on sof and resets to 0.
REQ-033 SHALL, when the macro is undefined, have neither the stall_cnt port nor its logic.

Verification
REQ-034 SHALL cover: slice_width=16, slices_per_line=2, frame_height=2, all in_valid=1, out_ready=1 -> 16 beats in order S0x4,S1x4,S0x4,S1x4, with out_sof on beat 0, out_eol on beats 7 and 15, out_eof on beat 15, then DONE.
REQ-035 SHALL cover: slice_width=10 -> 3 beats per slice line, with the third beat's pad pixels forwarded as-is.
REQ-036 SHALL cover: out_ready low for 5 cycles mid-line -> out_data_p held, in_ready[sel]=0, no beat lost or duplicated (and stall_cnt=5 with the macro defined).
REQ-037 SHALL cover: in_valid[1] high while sel=0 -> in_ready[1]=0 and slice 1 data not emitted.
REQ-038 SHALL cover: sof pulsed at beat 5 of line 0 -> out_valid=0 next cycle, then output restarts from slice 0 beat 0 with out_sof.
REQ-039 SHALL cover: rst_n asserted mid-frame -> all outputs 0 immediately, and in_ready stays 0 until sof.

Source files
------------

// File: rtl/output_slice_scheduler.sv
// ---------------------------------------------------------------------------
// output_slice_scheduler
//
// Purpose:
//   Serialises NUM_SLICES parallel slice streams into a single output stream.
//   Each picture line is made of slices_per_line slices. Every slice line is
//   ceil(slice_width/4) beats of 4 pixels x 3 components x 14 bits. The
//   slices are forwarded in order, slice 0 first, and the line counter
//   advances after the last slice. A single registered output stage gives
//   one cycle of latency and sustains one beat per cycle.
//
// Ports:
//   clk, rst_n        - clock (rising edge) and asynchronous active-low reset
//   sof               - start-of-frame pulse; latches the configuration and
//                       restarts the frame from any state
//   slice_width       - slice width in pixels
//   slices_per_line   - slices per line (0 is treated as 1, values above
//                       NUM_SLICES are treated as NUM_SLICES)
//   frame_height      - number of lines in the frame
//   in_valid/in_ready - per-slice input handshake
//   in_data_p         - per-slice beats, slice s at [s*168 +: 168]
//   out_valid/out_ready/out_data_p - output handshake and beat
//   out_sof/out_sol/out_eol/out_eof - frame/line markers, qualified by out_valid
//   stall_cnt         - present only with OUTPUT_SLICE_SCHEDULER_STALL_CNT_EN:
//                       saturating count of cycles with out_valid & ~out_ready
//
// Build option:
//   OUTPUT_SLICE_SCHEDULER_STALL_CNT_EN - adds the stall_cnt port and counter.
// ---------------------------------------------------------------------------
module output_slice_scheduler #(
    parameter int MAX_SLICE_WIDTH  = 2560,
    parameter int NUM_SLICES       = 4,
    parameter int MAX_FRAME_HEIGHT = 2160
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  sof,
    input  logic [$clog2(MAX_SLICE_WIDTH)-1:0]    slice_width,
    input  logic [$clog2(NUM_SLICES):0]           slices_per_line,
    input  logic [$clog2(MAX_FRAME_HEIGHT):0]     frame_height,
    input  logic [NUM_SLICES-1:0]                 in_valid,
    input  logic [NUM_SLICES*4*3*14-1:0]          in_data_p,
    output logic [NUM_SLICES-1:0]                 in_ready,
    output logic                                  out_valid,
    output logic [167:0]                          out_data_p,
    input  logic                                  out_ready,
    output logic                                  out_sof,
    output logic                                  out_sol,
    output logic                                  out_eol,
    output logic                                  out_eof
`ifdef OUTPUT_SLICE_SCHEDULER_STALL_CNT_EN
    ,
    output logic [31:0]                           stall_cnt
`endif
);

    localparam int DW     = 4 * 3 * 14;
    localparam int SW_W   = $clog2(MAX_SLICE_WIDTH);
    localparam int BEAT_W = SW_W - 1;
    localparam int SPL_W  = $clog2(NUM_SLICES) + 1;
    localparam int FH_W   = $clog2(MAX_FRAME_HEIGHT) + 1;
    localparam int SEL_W  = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state;
    logic [SEL_W-1:0]    sel;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [FH_W-1:0]     line_cnt;

    // Latched configuration, stored as "last index" values so the end-of-slice,
    // end-of-line and end-of-frame tests are plain equality compares.
    logic [BEAT_W-1:0]   beat_last;
    logic [SEL_W-1:0]    sel_last;
    logic [FH_W-1:0]     line_last;

    logic [BEAT_W-1:0]   beat_last_next;
    logic [SEL_W-1:0]    sel_last_next;
    logic [FH_W-1:0]     line_last_next;
    logic [SW_W:0]       width_round;
    logic [BEAT_W-1:0]   beats_per_slice;
    logic [SPL_W-1:0]    spl_clamped;

    logic                take;
    logic                is_last_beat;
    logic                is_last_slice;
    logic                is_last_line;
    logic [DW-1:0]       sel_data;

    // Turn the raw configuration inputs into last-index values. A zero slice
    // width or zero frame height is treated as one beat / one line so the
    // counters always have a reachable end and the frame cannot hang.
    always_comb begin
        width_round     = {1'b0, slice_width} + (SW_W + 1)'(3);
        beats_per_slice = width_round[SW_W:2];
        beat_last_next  = (beats_per_slice == '0) ? '0 : beats_per_slice - BEAT_W'(1);

        spl_clamped = slices_per_line;
        if (slices_per_line == '0) begin
            spl_clamped = SPL_W'(1);
        end else if (slices_per_line > SPL_W'(NUM_SLICES)) begin
            spl_clamped = SPL_W'(NUM_SLICES);
        end
        sel_last_next = SEL_W'(spl_clamped - SPL_W'(1));

        line_last_next = (frame_height == '0) ? '0 : frame_height - FH_W'(1);
    end

    // The configuration and the data register carry no reset: they are
    // meaningless until the first sof, and out_data_p is only looked at
    // while out_valid is high.
    always_ff @(posedge clk) begin
        if (sof) begin
            beat_last <= beat_last_next;
            sel_last  <= sel_last_next;
            line_last <= line_last_next;
        end
        if (take) begin
            out_data_p <= sel_data;
        end
    end

    assign sel_data      = in_data_p[int'(sel)*DW +: DW];
    assign is_last_beat  = (beat_cnt == beat_last);
    assign is_last_slice = (sel == sel_last);
    assign is_last_line  = (line_cnt == line_last);

    // A beat is taken from the selected slice only when the output stage is
    // empty or draining this cycle. sof overrides any transfer, so a beat
    // offered in the sof cycle is dropped.
    assign take = (state == ACTIVE) && !sof && in_valid[sel] && (!out_valid || out_ready);

    always_comb begin
        in_ready = '0;
        if ((state == ACTIVE) && (!out_valid || out_ready)) begin
            in_ready[sel] = 1'b1;
        end
    end

    // Main sequencer: state, position counters and the registered output
    // flags. The flags are computed from the counters of the beat being
    // taken, so they travel with their beat through the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_sol   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
            sel       <= '0;
            beat_cnt  <= '0;
            line_cnt  <= '0;
        end else if (sof) begin
            state     <= ACTIVE;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_sol   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
            sel       <= '0;
            beat_cnt  <= '0;
            line_cnt  <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_sof   <= (line_cnt == '0) && (sel == '0) && (beat_cnt == '0);
            out_sol   <= (sel == '0) && (beat_cnt == '0);
            out_eol   <= is_last_beat && is_last_slice;
            out_eof   <= is_last_beat && is_last_slice && is_last_line;

            if (is_last_beat) begin
                beat_cnt <= '0;
                if (is_last_slice) begin
                    sel      <= '0;
                    line_cnt <= line_cnt + FH_W'(1);
                    if (is_last_line) begin
                        state <= DONE;
                    end
                end else begin
                    sel <= sel + SEL_W'(1);
                end
            end else begin
                beat_cnt <= beat_cnt + BEAT_W'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_sol   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end
    end

`ifdef OUTPUT_SLICE_SCHEDULER_STALL_CNT_EN
    // Saturating back-pressure counter, restarted with every frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (sof) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_output_slice_scheduler.sv
// ---------------------------------------------------------------------------
// tb_output_slice_scheduler
//
// Purpose:
//   Self-checking bench for output_slice_scheduler. A table of per-cycle
//   records (inputs plus hand-computed expected outputs) is applied and
//   compared one cycle at a time, followed by hand-written reset sequences.
//   Each slice's upstream source emits beats tagged {slice, sequence}, and
//   its sequence number advances on every handshake, so a lost, duplicated
//   or wrong-slice beat shows up as a data mismatch.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_output_slice_scheduler;

    localparam int NS = 4;
    localparam int DW = 168;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sof;
    logic [11:0]       slice_width;
    logic [2:0]        slices_per_line;
    logic [12:0]       frame_height;
    logic [NS-1:0]     in_valid;
    logic [NS*DW-1:0]  in_data_p;
    logic [NS-1:0]     in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data_p;
    logic              out_ready;
    logic              out_sof;
    logic              out_sol;
    logic              out_eol;
    logic              out_eof;
`ifdef OUTPUT_SLICE_SCHEDULER_STALL_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    always #5 clk = ~clk;

    output_slice_scheduler #(
        .MAX_SLICE_WIDTH (2560),
        .NUM_SLICES      (NS),
        .MAX_FRAME_HEIGHT(2160)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sof            (sof),
        .slice_width    (slice_width),
        .slices_per_line(slices_per_line),
        .frame_height   (frame_height),
        .in_valid       (in_valid),
        .in_data_p      (in_data_p),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_data_p     (out_data_p),
        .out_ready      (out_ready),
        .out_sof        (out_sof),
        .out_sol        (out_sol),
        .out_eol        (out_eol),
        .out_eof        (out_eof)
`ifdef OUTPUT_SLICE_SCHEDULER_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    // One record per clock cycle. exp_flags is {sof, sol, eol, eof}; flags
    // and data are only compared when exp_valid is set.
    typedef struct {
        logic        clr;
        logic        sof;
        logic [11:0] sw;
        logic [2:0]  spl;
        logic [12:0] fh;
        logic [3:0]  in_valid;
        logic        out_ready;
        logic [3:0]  exp_ready;
        logic        exp_valid;
        logic [3:0]  exp_flags;
        int          exp_slice;
        int          exp_seq;
    } vec_t;

    vec_t        tbl[$];
    int          seq[NS];
    int          n_vectors;
    int          n_miscompares;
    int          stall_idx;
    logic [11:0] ph_sw;
    logic [2:0]  ph_spl;
    logic [12:0] ph_fh;

    // Beat tag: {slice, sequence} repeated across all 168 bits, so pad
    // pixels of a partial last beat are checked as well.
    function automatic logic [DW-1:0] mk_data(int s, int n);
        logic [23:0] w;
        w = {s[7:0], n[15:0]};
        return {7{w}};
    endfunction

    function automatic vec_t mk(logic clr, logic sf, logic [3:0] iv, logic ordy,
                                logic [3:0] er, logic ev, logic [3:0] ef, int es, int en);
        vec_t v;
        v.clr       = clr;
        v.sof       = sf;
        v.sw        = ph_sw;
        v.spl       = ph_spl;
        v.fh        = ph_fh;
        v.in_valid  = iv;
        v.out_ready = ordy;
        v.exp_ready = er;
        v.exp_valid = ev;
        v.exp_flags = ef;
        v.exp_slice = es;
        v.exp_seq   = en;
        return v;
    endfunction

    task automatic checkVal(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(vec_t v, int idx);
        checkVal($sformatf("v%0d in_ready", idx), DW'(in_ready), DW'(v.exp_ready));
        checkVal($sformatf("v%0d out_valid", idx), DW'(out_valid), DW'(v.exp_valid));
        if (v.exp_valid) begin
            checkVal($sformatf("v%0d flags", idx),
                     DW'({out_sof, out_sol, out_eol, out_eof}), DW'(v.exp_flags));
            checkVal($sformatf("v%0d data", idx), out_data_p, mk_data(v.exp_slice, v.exp_seq));
        end
    endtask

    // Drive one cycle: inputs at the falling edge, compare 1 ns later, then
    // advance the upstream sequence numbers for every handshake at the
    // rising edge (the upstream also believes a beat offered during sof
    // was taken).
    task automatic applyStimulus(vec_t v, int idx);
        logic [NS-1:0] fire;
        @(negedge clk);
        if (v.clr) begin
            for (int s = 0; s < NS; s++) seq[s] = 0;
        end
        sof             = v.sof;
        slice_width     = v.sw;
        slices_per_line = v.spl;
        frame_height    = v.fh;
        in_valid        = v.in_valid;
        out_ready       = v.out_ready;
        for (int s = 0; s < NS; s++) in_data_p[s*DW +: DW] = mk_data(s, seq[s]);
        #1;
        checkOutput(v, idx);
        fire = in_valid & in_ready;
        @(posedge clk);
        for (int s = 0; s < NS; s++) if (fire[s]) seq[s]++;
    endtask

    task automatic checkIdleOutputs(string tag);
        checkVal({tag, " out_valid"}, DW'(out_valid), '0);
        checkVal({tag, " in_ready"}, DW'(in_ready), '0);
        checkVal({tag, " flags"}, DW'({out_sof, out_sol, out_eol, out_eof}), '0);
`ifdef OUTPUT_SLICE_SCHEDULER_STALL_CNT_EN
        checkVal({tag, " stall_cnt"}, DW'(stall_cnt), '0);
`endif
    endtask

    task automatic buildTable();
        // Two slices of 16 px (4 beats), two lines, free-flowing.
        ph_sw = 12'd16; ph_spl = 3'd2; ph_fh = 13'd2;
        tbl.push_back(mk(1, 1, 4'hF, 1, 4'h0, 0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h1, 0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h1, 1, 4'hC, 0, 0));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h1, 1, 4'h0, 0, 1));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h1, 1, 4'h0, 0, 2));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h2, 1, 4'h0, 0, 3));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h2, 1, 4'h0, 1, 0));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h2, 1, 4'h0, 1, 1));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h2, 1, 4'h0, 1, 2));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h1, 1, 4'h2, 1, 3));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h1, 1, 4'h4, 0, 4));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h1, 1, 4'h0, 0, 5));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h1, 1, 4'h0, 0, 6));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h2, 1, 4'h0, 0, 7));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h2, 1, 4'h0, 1, 4));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h2, 1, 4'h0, 1, 5));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h2, 1, 4'h0, 1, 6));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h0, 1, 4'h3, 1, 7));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h0, 0, 4'h0, 0, 0));

        // 10 px -> 3 beats, slices_per_line=0 acts as 1, one line. Slice 1
        // is valid while slice 0 is selected and must never be taken.
        ph_sw = 12'd10; ph_spl = 3'd0; ph_fh = 13'd1;
        tbl.push_back(mk(1, 1, 4'h0, 1, 4'h0, 0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 0, 4'h2, 1, 4'h1, 0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 0, 4'h2, 1, 4'h1, 0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 0, 4'h3, 1, 4'h1, 0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 0, 4'h3, 1, 4'h1, 1, 4'hC, 0, 0));
        tbl.push_back(mk(0, 0, 4'h3, 1, 4'h1, 1, 4'h0, 0, 1));
        tbl.push_back(mk(0, 0, 4'h3, 1, 4'h0, 1, 4'h3, 0, 2));
        tbl.push_back(mk(0, 0, 4'h3, 1, 4'h0, 0, 4'h0, 0, 0));

        // Back-pressure: out_ready low for 5 cycles while beat S0#1 is held.
        ph_sw = 12'd16; ph_spl = 3'd2; ph_fh = 13'd1;
        tbl.push_back(mk(1, 1, 4'hF, 1, 4'h0, 0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h1, 0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h1, 1, 4'hC, 0, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 4'hF, 0, 4'h0, 1, 4'h0, 0, 1));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h1, 1, 4'h0, 0, 1));
        stall_idx = tbl.size();
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h1, 1, 4'h0, 0, 2));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h2, 1, 4'h0, 0, 3));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h2, 1, 4'h0, 1, 0));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h2, 1, 4'h0, 1, 1));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h2, 1, 4'h0, 1, 2));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h0, 1, 4'h3, 1, 3));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h0, 0, 4'h0, 0, 0));

        // sof while beat 5 (S1 beat 1) is offered: that beat is dropped and
        // the frame restarts at slice 0 beat 0 with out_sof.
        ph_sw = 12'd16; ph_spl = 3'd2; ph_fh = 13'd2;
        tbl.push_back(mk(1, 1, 4'hF, 1, 4'h0, 0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h1, 0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h1, 1, 4'hC, 0, 0));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h1, 1, 4'h0, 0, 1));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h1, 1, 4'h0, 0, 2));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h2, 1, 4'h0, 0, 3));
        tbl.push_back(mk(0, 1, 4'hF, 1, 4'h2, 1, 4'h0, 1, 0));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h1, 0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h1, 1, 4'hC, 0, 4));
        tbl.push_back(mk(0, 0, 4'hF, 1, 4'h1, 1, 4'h0, 0, 5));
    endtask

    initial begin
        n_vectors       = 0;
        n_miscompares   = 0;
        stall_idx       = -1;
        rst_n           = 1'b0;
        sof             = 1'b0;
        slice_width     = '0;
        slices_per_line = '0;
        frame_height    = '0;
        in_valid        = '0;
        in_data_p       = '0;
        out_ready       = 1'b1;
        for (int s = 0; s < NS; s++) seq[s] = 0;

        repeat (2) @(negedge clk);
        #1;
        checkIdleOutputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        buildTable();
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i], i);
`ifdef OUTPUT_SLICE_SCHEDULER_STALL_CNT_EN
            if (i == stall_idx) checkVal("stall_cnt", DW'(stall_cnt), DW'(32'd5));
`endif
        end

        // Reset in the middle of a line: everything drops at once, without
        // waiting for a clock edge, and nothing restarts until the next sof.
        in_valid  = 4'hF;
        out_ready = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkVal($sformatf("post_rst%0d in_ready", i), DW'(in_ready), '0);
            checkVal($sformatf("post_rst%0d out_valid", i), DW'(out_valid), '0);
        end
        @(negedge clk);
        sof             = 1'b1;
        slice_width     = 12'd16;
        slices_per_line = 3'd2;
        frame_height    = 13'd2;
        #1;
        checkVal("rst_sof in_ready", DW'(in_ready), '0);
        @(negedge clk);
        sof = 1'b0;
        #1;
        checkVal("rst_restart in_ready", DW'(in_ready), DW'(4'h1));
        @(negedge clk);
        #1;
        checkVal("rst_restart out_valid", DW'(out_valid), DW'(1'b1));
        checkVal("rst_restart out_sof", DW'(out_sof), DW'(1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
